// File: rtl/fetch_stage_ctrl.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch-state FSM.
// Optional stall/flush performance counters are built when FETCH_PERF_COUNT_EN is defined.
module fetch_stage_ctrl #(
    parameter int              PC_W     = 12,
    parameter int              INST_W   = 19,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              pc_writebar,
    input  logic              if_id_loadbar,
    input  logic              if_id_flush,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_target,
    output logic [INST_W-1:0] if_id_instruction,
    output logic [PC_W-1:0]   if_id_pc_plus1,
    output logic              if_id_valid,
    output logic [1:0]        fetch_state,
    output logic [15:0]       stall_count,
    output logic [15:0]       flush_count
);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STALL  = 2'd2,
        ST_BUBBLE = 2'd3
    } fetch_state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [PC_W-1:0]   r_pc;
    logic [INST_W-1:0] r_inst;
    logic [PC_W-1:0]   r_pc_plus1;
    logic              r_valid;
    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [PC_W-1:0]   w_pc_plus1;
    logic              w_stall_both;

    assign w_pc_plus1   = r_pc + PC_ONE;
    // A redirect overrides the PC stall, so such a cycle is never a full stall.
    assign w_stall_both = pc_writebar & if_id_loadbar & ~redirect_valid;

    assign imem_addr         = r_pc;
    assign if_id_instruction = r_inst;
    assign if_id_pc_plus1    = r_pc_plus1;
    assign if_id_valid       = r_valid;
    assign fetch_state       = r_state;

    // PC register: redirect beats stall beats sequential advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_target;
        end else if (!pc_writebar) begin
            r_pc <= w_pc_plus1;
        end else begin
            r_pc <= r_pc;
        end
    end

    // IF/ID register: flush inserts a NOP, loadbar holds, otherwise capture the fetch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_inst     <= {INST_W{1'b0}};
            r_pc_plus1 <= {PC_W{1'b0}};
            r_valid    <= 1'b0;
        end else if (if_id_flush) begin
            r_inst     <= {INST_W{1'b0}};
            r_pc_plus1 <= r_pc_plus1;
            r_valid    <= 1'b0;
        end else if (!if_id_loadbar) begin
            r_inst     <= imem_data;
            r_pc_plus1 <= w_pc_plus1;
            r_valid    <= 1'b1;
        end else begin
            r_inst     <= r_inst;
            r_pc_plus1 <= r_pc_plus1;
            r_valid    <= r_valid;
        end
    end

    // Fetch FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Fetch FSM next-state logic; a flush from any state forces BUBBLE.
    always_comb begin
        w_state_next = r_state;
        if (if_id_flush) begin
            w_state_next = ST_BUBBLE;
        end else begin
            case (r_state)
                ST_FILL:   w_state_next = ST_RUN;
                ST_RUN:    w_state_next = w_stall_both ? ST_STALL : ST_RUN;
                ST_STALL: begin
                    if (redirect_valid || (!pc_writebar && !if_id_loadbar)) begin
                        w_state_next = ST_RUN;
                    end else begin
                        w_state_next = ST_STALL;
                    end
                end
                ST_BUBBLE: w_state_next = w_stall_both ? ST_STALL : ST_RUN;
                default:   w_state_next = ST_FILL;
            endcase
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    // Saturating stall/flush event counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_count <= 16'h0000;
            r_flush_count <= 16'h0000;
        end else begin
            if (pc_writebar && !redirect_valid && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'h0001;
            end else begin
                r_stall_count <= r_stall_count;
            end
            if (if_id_flush && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'h0001;
            end else begin
                r_flush_count <= r_flush_count;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
`else
    assign stall_count = 16'h0000;
    assign flush_count = 16'h0000;
`endif

endmodule
